cache_mem_arbiter: RTL and testbench

Sequencer between the two-port (I-side port1 / D-side port2) cache miss/write-through interface and a single-port main memory, plus the DMA bus-request/grant handshake.
- Snapshots all concurrently pending cache operations and serialises them onto the memory port.
- Returns both 64-bit lines and pulses mem_signal once, after every snapshotted operation has completed.
- Grants the memory bus to DMA only between cache transactions.

---
 rtl/cache_mem_arbiter_if.sv | 37 +++
 rtl/cache_mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_mem_arbiter_if.sv
// Signal bundle between cache_mem_arbiter, the two-port cache, main memory and the DMA master.
// slave = arbiter side, master = environment (cache, memory, DMA) side.
interface cache_mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16,
    parameter int LINE_W = 64
);
    logic              mem_read_m1;
    logic              mem_read_m2;
    logic              mem_write_m2;
    logic [ADDR_W-1:0] mem_address1;
    logic [ADDR_W-1:0] mem_address2;
    logic [WORD_W-1:0] mem_write_data;
    logic              mem_signal;
    logic [LINE_W-1:0] mem_data1;
    logic [LINE_W-1:0] mem_data2;
    logic              br;
    logic              bg;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [WORD_W-1:0] m_wdata;
    logic [LINE_W-1:0] m_rdata;
    logic              m_ack;

    modport slave (
        input  mem_read_m1, mem_read_m2, mem_write_m2, mem_address1, mem_address2,
               mem_write_data, br, m_rdata, m_ack,
        output mem_signal, mem_data1, mem_data2, bg, m_req, m_we, m_addr, m_wdata
    );

    modport master (
        output mem_read_m1, mem_read_m2, mem_write_m2, mem_address1, mem_address2,
               mem_write_data, br, m_rdata, m_ack,
        input  mem_signal, mem_data1, mem_data2, bg, m_req, m_we, m_addr, m_wdata
    );
endinterface

// File: rtl/cache_mem_arbiter.sv
// Serialises snapshotted cache fills/write-throughs onto one memory port and grants the bus to DMA.
// Optional DMA_FAIR_EN: after a DMA exit, a pending cache request wins over br once.
//
// state | meaning
// IDLE  | waiting; samples br and cache requests
// RD1   | port1 line read outstanding
// RD2   | port2 line read outstanding
// WR2   | port2 word write outstanding
// GAP   | one request-free cycle between ops
// DONE  | mem_signal pulse, lines valid
// DMA   | bus granted to DMA
module cache_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int WORD_W = 16,
    parameter int LINE_W = 64
) (
    input logic                clk,
    input logic                reset_n,
    cache_mem_arbiter_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD1, RD2, WR2, GAP, DONE, DMA} state_t;

    state_t state, next_state;

    logic              f_rd1, f_rd2, f_wr2;
    logic [ADDR_W-1:0] snap_a1, snap_a2;
    logic [WORD_W-1:0] snap_wd;

    logic              v_rd1, v_rd2, v_wr2;
    logic [ADDR_W-1:0] v_a1, v_a2;
    logic [WORD_W-1:0] v_wd;
    logic              r_rd1, r_rd2, r_wr2;
    logic              any_req, cache_wins, op_ack;

    logic              mem_signal_q, bg_q, m_req_q, m_we_q;
    logic [ADDR_W-1:0] m_addr_q;
    logic [WORD_W-1:0] m_wdata_q;
    logic [LINE_W-1:0] data1_q, data2_q;

    logic              mem_signal_d, bg_d, m_req_d, m_we_d;
    logic [ADDR_W-1:0] m_addr_d;
    logic [WORD_W-1:0] m_wdata_d;
    logic [LINE_W-1:0] data1_d, data2_d;

    function automatic state_t first_op(input logic rd1, input logic rd2, input logic wr2);
        if (rd1)      return RD1;
        else if (rd2) return RD2;
        else if (wr2) return WR2;
        else          return DONE;
    endfunction

    // In IDLE the decision is taken on the live inputs; afterwards only the snapshot counts.
    always_comb begin
        if (state == IDLE) begin
            v_rd1 = bus.mem_read_m1;
            v_rd2 = bus.mem_read_m2 & ~bus.mem_write_m2;
            v_wr2 = bus.mem_write_m2;
            v_a1  = bus.mem_address1;
            v_a2  = bus.mem_address2;
            v_wd  = bus.mem_write_data;
        end else begin
            v_rd1 = f_rd1;
            v_rd2 = f_rd2;
            v_wr2 = f_wr2;
            v_a1  = snap_a1;
            v_a2  = snap_a2;
            v_wd  = snap_wd;
        end
        r_rd1   = v_rd1 & (state != RD1);
        r_rd2   = v_rd2 & (state != RD2);
        r_wr2   = v_wr2 & (state != WR2);
        any_req = v_rd1 | v_rd2 | v_wr2;
        op_ack  = bus.m_ack & m_req_q & ((state == RD1) | (state == RD2) | (state == WR2));
    end

`ifdef DMA_FAIR_EN
    logic fair_flag;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                    fair_flag <= 1'b0;
        else if (state == DMA && !bus.br) fair_flag <= 1'b1;
        else if (state == IDLE)           fair_flag <= 1'b0;
    end

    assign cache_wins = any_req & (~bus.br | fair_flag);
`else
    assign cache_wins = any_req & ~bus.br;
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cache_wins)  next_state = first_op(v_rd1, v_rd2, v_wr2);
                else if (bus.br) next_state = DMA;
            end
            RD1, RD2, WR2: begin
                if (op_ack) next_state = (r_rd1 | r_rd2 | r_wr2) ? GAP : DONE;
            end
            GAP:     next_state = first_op(f_rd1, f_rd2, f_wr2);
            DONE:    next_state = IDLE;
            DMA:     if (!bus.br) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Next values of the registered outputs, derived from the state being entered.
    always_comb begin
        m_req_d      = (next_state == RD1) | (next_state == RD2) | (next_state == WR2);
        m_we_d       = (next_state == WR2);
        bg_d         = (next_state == DMA);
        mem_signal_d = (next_state == DONE);
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        case (next_state)
            RD1: m_addr_d = {v_a1[ADDR_W-1:2], 2'b00};
            RD2: m_addr_d = {v_a2[ADDR_W-1:2], 2'b00};
            WR2: begin
                m_addr_d  = v_a2;
                m_wdata_d = v_wd;
            end
            default: ;
        endcase
        data1_d = data1_q;
        data2_d = data2_q;
        if (op_ack && state == RD1) data1_d = bus.m_rdata;
        if (op_ack && state == RD2) data2_d = bus.m_rdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            f_rd1        <= 1'b0;
            f_rd2        <= 1'b0;
            f_wr2        <= 1'b0;
            snap_a1      <= '0;
            snap_a2      <= '0;
            snap_wd      <= '0;
            mem_signal_q <= 1'b0;
            bg_q         <= 1'b0;
            m_req_q      <= 1'b0;
            m_we_q       <= 1'b0;
            m_addr_q     <= '0;
            m_wdata_q    <= '0;
            data1_q      <= '0;
            data2_q      <= '0;
        end else begin
            state        <= next_state;
            mem_signal_q <= mem_signal_d;
            bg_q         <= bg_d;
            m_req_q      <= m_req_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            data1_q      <= data1_d;
            data2_q      <= data2_d;
            if (state == IDLE && cache_wins) begin
                f_rd1   <= v_rd1;
                f_rd2   <= v_rd2;
                f_wr2   <= v_wr2;
                snap_a1 <= bus.mem_address1;
                snap_a2 <= bus.mem_address2;
                snap_wd <= bus.mem_write_data;
            end else if (op_ack) begin
                f_rd1 <= r_rd1;
                f_rd2 <= r_rd2;
                f_wr2 <= r_wr2;
            end
        end
    end

    assign bus.mem_signal = mem_signal_q;
    assign bus.bg         = bg_q;
    assign bus.m_req      = m_req_q;
    assign bus.m_we       = m_we_q;
    assign bus.m_addr     = m_addr_q;
    assign bus.m_wdata    = m_wdata_q;
    assign bus.mem_data1  = data1_q;
    assign bus.mem_data2  = data2_q;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: expected memory ops and completions are queued at stimulus time.
module tb_cache_mem_arbiter;
    localparam int ADDR_W = 16;
    localparam int WORD_W = 16;
    localparam int LINE_W = 64;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_W(LINE_W)) bus ();

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .WORD_W(WORD_W), .LINE_W(LINE_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        int          dly;
    } mem_op_t;

    typedef struct {
        logic [63:0] d1;
        logic [63:0] d2;
    } done_t;

    mem_op_t exp_mem[$];
    done_t   exp_done[$];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    logic [63:0] exp_d1 = '0;
    logic [63:0] exp_d2 = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] line_of(input logic [15:0] a);
        if (a == 16'h0034) return 64'h4444_3333_2222_1111;
        return {a ^ 16'hA5A5, a, ~a, a + 16'h1111};
    endfunction

    // Memory responder plus output monitor; one process so their ordering is fixed.
    mem_op_t cur;
    done_t   dn;
    logic    in_flight = 1'b0;
    logic    in_txn = 1'b0;
    logic    prev_req = 1'b0;
    logic    prev_sig = 1'b0;
    logic    stray_ack = 1'b0;
    int      cnt = 0;
    int      last_ack_cyc = -10;
    int      sig_count = 0;

    always @(negedge clk) begin
        cyc++;
        if (!reset_n) begin
            in_flight   = 1'b0;
            in_txn      = 1'b0;
            prev_req    = 1'b0;
            prev_sig    = 1'b0;
            bus.m_ack   = 1'b0;
            bus.m_rdata = '0;
        end else begin
            if (bus.mem_signal) begin
                sig_count++;
                chk("sig_pulse_width", 64'(prev_sig), 64'd0);
                chk("sig_latency", 64'(cyc - last_ack_cyc), 64'd1);
                chk("sig_expected", 64'(exp_done.size() > 0), 64'd1);
                if (exp_done.size() > 0) begin
                    dn = exp_done.pop_front();
                    chk("mem_data1", bus.mem_data1, dn.d1);
                    chk("mem_data2", bus.mem_data2, dn.d2);
                end
                in_txn = 1'b0;
            end
            if (bus.m_req && !prev_req && in_txn)
                chk("gap_cycles", 64'(cyc - last_ack_cyc), 64'd2);
            if (bus.bg)
                chk("req_during_bg", 64'(bus.m_req), 64'd0);
            prev_req = bus.m_req;
            prev_sig = bus.mem_signal;

            bus.m_ack = 1'b0;
            if (stray_ack) begin
                bus.m_ack = 1'b1;
                stray_ack = 1'b0;
            end else if (bus.m_req) begin
                if (!in_flight) begin
                    chk("req_expected", 64'(exp_mem.size() > 0), 64'd1);
                    if (exp_mem.size() > 0) begin
                        cur = exp_mem.pop_front();
                    end else begin
                        cur.we = bus.m_we; cur.addr = bus.m_addr; cur.wdata = bus.m_wdata; cur.dly = 0;
                    end
                    chk("op_we", 64'(bus.m_we), 64'(cur.we));
                    chk("op_addr", 64'(bus.m_addr), 64'(cur.addr));
                    if (cur.we) chk("op_wdata", 64'(bus.m_wdata), 64'(cur.wdata));
                    in_flight = 1'b1;
                    cnt = cur.dly;
                end else begin
                    chk("addr_stable", 64'(bus.m_addr), 64'(cur.addr));
                    chk("we_stable", 64'(bus.m_we), 64'(cur.we));
                end
                if (cnt == 0) begin
                    bus.m_ack    = 1'b1;
                    bus.m_rdata  = line_of(bus.m_addr);
                    in_flight    = 1'b0;
                    in_txn       = 1'b1;
                    last_ack_cyc = cyc;
                end else begin
                    cnt--;
                end
            end
        end
    end

    task automatic start_txn(input logic r1, input logic r2, input logic w2,
                             input logic [15:0] a1, input logic [15:0] a2, input logic [15:0] wd,
                             input int dly, input bit want_done);
        mem_op_t op;
        done_t   d;
        if (r1) begin
            op.we = 1'b0; op.addr = {a1[15:2], 2'b00}; op.wdata = '0; op.dly = dly;
            exp_mem.push_back(op);
            exp_d1 = line_of(op.addr);
        end
        if (r2 && !w2) begin
            op.we = 1'b0; op.addr = {a2[15:2], 2'b00}; op.wdata = '0; op.dly = dly;
            exp_mem.push_back(op);
            exp_d2 = line_of(op.addr);
        end
        if (w2) begin
            op.we = 1'b1; op.addr = a2; op.wdata = wd; op.dly = dly;
            exp_mem.push_back(op);
        end
        if (want_done) begin
            d.d1 = exp_d1;
            d.d2 = exp_d2;
            exp_done.push_back(d);
        end
        bus.mem_read_m1    = r1;
        bus.mem_read_m2    = r2;
        bus.mem_write_m2   = w2;
        bus.mem_address1   = a1;
        bus.mem_address2   = a2;
        bus.mem_write_data = wd;
    endtask

    // Requests drop and the request fields are scrambled once the arbiter has taken its snapshot.
    task automatic drop_reqs();
        bus.mem_read_m1    = 1'b0;
        bus.mem_read_m2    = 1'b0;
        bus.mem_write_m2   = 1'b0;
        bus.mem_address1   = 16'($urandom);
        bus.mem_address2   = 16'($urandom);
        bus.mem_write_data = 16'($urandom);
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.m_req) drop_reqs();
            if (bus.mem_signal) seen = 1'b1;
        end
        chk({tag, "_done"}, 64'(seen), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc0;
        bit seen;
        bus.mem_read_m1 = 1'b0; bus.mem_read_m2 = 1'b0; bus.mem_write_m2 = 1'b0;
        bus.mem_address1 = '0; bus.mem_address2 = '0; bus.mem_write_data = '0;
        bus.br = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_mem_signal", 64'(bus.mem_signal), 64'd0);
        chk("rst_bg", 64'(bus.bg), 64'd0);
        chk("rst_m_req", 64'(bus.m_req), 64'd0);
        chk("rst_m_we", 64'(bus.m_we), 64'd0);
        chk("rst_m_addr", 64'(bus.m_addr), 64'd0);
        chk("rst_m_wdata", 64'(bus.m_wdata), 64'd0);
        chk("rst_data1", bus.mem_data1, 64'd0);
        chk("rst_data2", bus.mem_data2, 64'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single fill, memory waits 3 cycles
        start_txn(1'b1, 1'b0, 1'b0, 16'h0036, 16'h0000, 16'h0000, 3, 1'b1);
        @(negedge clk);
        chk("fill_req_latency", 64'(bus.m_req), 64'd1);
        chk("fill_addr", 64'(bus.m_addr), 64'h0034);
        chk("fill_we", 64'(bus.m_we), 64'd0);
        wait_done("fill");
        chk("fill_data_hold", bus.mem_data1, 64'h4444_3333_2222_1111);

        // port1 read plus port2 write, zero-wait memory
        start_txn(1'b1, 1'b0, 1'b1, 16'h0010, 16'h0021, 16'hBEEF, 0, 1'b1);
        wait_done("combined");

        start_txn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0105, 16'h0000, 2, 1'b1);
        wait_done("p2_read");

        // port2 read and write together: write only, mem_data2 untouched
        start_txn(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0042, 16'h1234, 1, 1'b1);
        wait_done("p2_rw");
        chk("p2_rw_data2_kept", bus.mem_data2, line_of(16'h0104));

        start_txn(1'b1, 1'b1, 1'b0, 16'h00AB, 16'h0333, 16'h0000, 1, 1'b1);
        wait_done("two_reads");

        // DMA in IDLE: br high 5 cycles
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            chk("dma_bg", 64'(bus.bg), 64'((i >= 1 && i <= 5) ? 1 : 0));
            bus.br = (i < 5);
        end
        repeat (2) @(negedge clk);

        // br raised during RD1: grant only after DONE
        start_txn(1'b1, 1'b0, 1'b0, 16'h0120, 16'h0000, 16'h0000, 4, 1'b1);
        @(negedge clk);
        drop_reqs();
        bus.br = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            chk("bg_in_txn", 64'(bus.bg), 64'd0);
            if (bus.mem_signal) seen = 1'b1;
        end
        chk("br_txn_done", 64'(seen), 64'd1);
        @(negedge clk);
        chk("bg_after_done_idle", 64'(bus.bg), 64'd0);
        @(negedge clk);
        chk("bg_after_done", 64'(bus.bg), 64'd1);
        bus.br = 1'b0;
        repeat (3) @(negedge clk);

        // fairness: cache request pending when DMA releases for one cycle
        bus.br = 1'b1;
        repeat (3) @(negedge clk);
        start_txn(1'b1, 1'b0, 1'b0, 16'h0777, 16'h0000, 16'h0000, 0, 1'b1);
        @(negedge clk);
        bus.br = 1'b0;
        @(negedge clk);
        bus.br = 1'b1;
        @(negedge clk);
`ifdef DMA_FAIR_EN
        chk("fair_req", 64'(bus.m_req), 64'd1);
        chk("fair_bg", 64'(bus.bg), 64'd0);
`else
        chk("fair_req", 64'(bus.m_req), 64'd0);
        chk("fair_bg", 64'(bus.bg), 64'd1);
`endif
        bus.br = 1'b0;
        wait_done("fair");

        // reset in the middle of a slow RD2
        start_txn(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0200, 16'h0000, 20, 1'b0);
        @(negedge clk);
        drop_reqs();
        repeat (3) @(negedge clk);
        chk("pre_rst_req", 64'(bus.m_req), 64'd1);
        sc0 = sig_count;
        reset_n = 1'b0;
        #1;
        chk("midrst_m_req", 64'(bus.m_req), 64'd0);
        chk("midrst_bg", 64'(bus.bg), 64'd0);
        chk("midrst_sig", 64'(bus.mem_signal), 64'd0);
        chk("midrst_data1", bus.mem_data1, 64'd0);
        exp_d1 = '0;
        exp_d2 = '0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        stray_ack = 1'b1;
        repeat (4) @(negedge clk);
        chk("stray_ack_no_sig", 64'(sig_count - sc0), 64'd0);
        chk("stray_ack_no_req", 64'(bus.m_req), 64'd0);

        start_txn(1'b1, 1'b0, 1'b0, 16'h0036, 16'h0000, 16'h0000, 0, 1'b1);
        wait_done("post_reset");
        chk("mem_q_empty", 64'(exp_mem.size()), 64'd0);
        chk("done_q_empty", 64'(exp_done.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
